cla_nibble_sequencer: RTL and testbench

Multi-word adder front end that sits directly upstream of the 4-bit carry-lookahead adder slice (a, b, cin -> s, carryout). It latches two WIDTH-bit operands and feeds the slice one nibble per clock, LSB nibble first, chaining the slice's carry-out into the next nibble's carry-in through a register. It assembles the WIDTH-bit sum and the final carry, then reports completion with a one-cycle done pulse. The slice itself stays external and purely combinational; this block owns all sequencing.

---
 rtl/cla_nibble_sequencer.sv | 125 ++++++++++++
 tb/tb_cla_nibble_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cla_nibble_sequencer
//  Description : Sequences a WIDTH-bit addition through an external 4-bit
//                combinational carry-lookahead slice, one nibble per clock,
//                LSB nibble first. The nibble carry is chained through a
//                register. The assembled sum and final carry are presented
//                with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_s,
  input  logic             cla_cout
);

  // WIDTH must be a non-zero multiple of 4; NIB is derived and not overridable.
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] c_last_idx = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_run;
  logic [WIDTH-1:0] w_work_next;

  assign w_run = (r_state == S_RUN);

  // Slice inputs: current operand nibbles and chained carry while running, 0 otherwise.
  assign cla_a   = w_run ? 4'(r_a >> {r_idx, 2'b00}) : 4'd0;
  assign cla_b   = w_run ? 4'(r_b >> {r_idx, 2'b00}) : 4'd0;
  assign cla_cin = w_run ? r_carry : 1'b0;

  // Status is decoded straight from the state register, no extra delay.
  assign busy = w_run;
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

  // Working value with the slice result merged into the current nibble, so the
  // final edge can load sum including the nibble captured on that same edge.
  always_comb begin
    w_work_next = r_work;
    for (int n = 0; n < NIB; n++) begin
      if (r_idx == IDXW'(n)) begin
        w_work_next[4*n +: 4] = cla_s;
      end
    end
  end

  // Sequencer FSM: latch operands, step nibbles, publish result, then idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_carry <= cin;
            r_idx   <= '0;
            r_work  <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_work  <= w_work_next;
          r_carry <= cla_cout;
          if (r_idx == c_last_idx) begin
            // Index wraps to 0 rather than running past the last nibble.
            r_idx   <= '0;
            r_sum   <= w_work_next;
            r_cout  <= cla_cout;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_nibble_sequencer
//  Description : Self-checking bench for cla_nibble_sequencer (WIDTH=16) with
//                a behavioural 4-bit adder slice on the cla_* ports. Results
//                are predicted with plain integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_nibble_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic [3:0]  cla_a;
  logic [3:0]  cla_b;
  logic        cla_cin;
  logic [3:0]  cla_s;
  logic        cla_cout;

  int          n_vec;
  int          n_err;
  logic [15:0] exp_sum;
  logic        exp_cout;

  cla_nibble_sequencer #(.WIDTH(16)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .cla_a    (cla_a),
    .cla_b    (cla_b),
    .cla_cin  (cla_cin),
    .cla_s    (cla_s),
    .cla_cout (cla_cout)
  );

  // Behavioural 4-bit adder slice.
  assign {cla_cout, cla_s} = 5'(cla_a) + 5'(cla_b) + 5'(cla_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One full addition with per-cycle checks of the slice interface.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] res;
    logic [31:0] mask;
    logic [31:0] carry_in;
    res = 17'(a) + 17'(b) + 17'(c);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cla_a", 32'(cla_a), 32'd0);
    check("idle_cla_cin", 32'(cla_cin), 32'd0);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    cin   = c;
    @(negedge clk);
    start = 1'b0;
    op_a  = 16'($urandom);
    op_b  = 16'($urandom);
    cin   = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      mask     = (32'd1 << (4 * i)) - 32'd1;
      carry_in = ((32'(a) & mask) + (32'(b) & mask) + 32'(c)) >> (4 * i);
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      check("run_cla_a", 32'(cla_a), (32'(a) >> (4 * i)) & 32'hF);
      check("run_cla_b", 32'(cla_b), (32'(b) >> (4 * i)) & 32'hF);
      check("run_cla_cin", 32'(cla_cin), carry_in);
      check("run_sum_hold", 32'(sum), 32'(exp_sum));
      check("run_cout_hold", 32'(cout), 32'(exp_cout));
      @(negedge clk);
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_sum", 32'(sum), 32'(res[15:0]));
    check("done_cout", 32'(cout), 32'(res[16]));
    check("done_cla_a", 32'(cla_a), 32'd0);
    exp_sum  = res[15:0];
    exp_cout = res[16];
    @(negedge clk);
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_sum", 32'(sum), 32'(exp_sum));
  endtask

  logic [15:0] ha [0:18];
  logic [15:0] hb [0:18];
  logic        hc [0:18];

  initial begin
    logic [16:0] res;
    logic        exp_done;
    n_vec    = 0;
    n_err    = 0;
    exp_sum  = 16'h0;
    exp_cout = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    op_a     = 16'h0;
    op_b     = 16'h0;
    cin      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_cla_a", 32'(cla_a), 32'd0);
    rst = 1'b0;

    // No carry anywhere, then carry rippling through every nibble
    run_op(16'h0001, 16'hFFFE, 1'b0);
    run_op(16'h0001, 16'hFFFE, 1'b1);

    // Reset two cycles into a run aborts it and clears the result
    @(negedge clk);
    start = 1'b1; op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    exp_sum  = 16'h0;
    exp_cout = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    run_op(16'h0001, 16'h0001, 1'b0);

    // Nibble stepping and all-ones with carry
    run_op(16'h0777, 16'h0777, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1);

    // start held high with operands churning: accepts every NIB+2 cycles
    @(negedge clk);
    ha[0] = 16'($urandom); hb[0] = 16'($urandom); hc[0] = 1'($urandom);
    start = 1'b1; op_a = ha[0]; op_b = hb[0]; cin = hc[0];
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      exp_done = (n >= 5) && (((n - 5) % 6) == 0);
      check("hold_done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        res      = 17'(ha[n-5]) + 17'(hb[n-5]) + 17'(hc[n-5]);
        exp_sum  = res[15:0];
        exp_cout = res[16];
      end
      check("hold_sum", 32'(sum), 32'(exp_sum));
      check("hold_cout", 32'(cout), 32'(exp_cout));
      ha[n] = 16'($urandom); hb[n] = 16'($urandom); hc[n] = 1'($urandom);
      op_a = ha[n]; op_b = hb[n]; cin = hc[n];
      if (n == 18) start = 1'b0;
    end

    // Random operands
    for (int k = 0; k < 20; k++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got stalled run, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
